// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared widths, timeout default and state encoding for the fetch sequencer
// Optional feature macro: FETCH_TIMEOUT_EN (uses FETCH_TIMEOUT_CYCLES).
package fetch_pkg;

  localparam int FETCH_DATA_W         = 16;
  localparam int FETCH_ADDR_W         = 16;
  localparam int FETCH_TIMEOUT_CYCLES = 15;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    REDIR = 3'd3,
    ERR   = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_timeout_ctr.sv
// rtl/fetch_timeout_ctr.sv - wait-cycle counter for a pending memory read
// Only instantiated when FETCH_TIMEOUT_EN is defined.
import fetch_pkg::*;

module fetch_timeout_ctr #(
  parameter int LIMIT = FETCH_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  // Flags the cycle whose un-acked edge would make the count reach LIMIT.
  assign expired = enable && (count == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fetch_seq.sv
// rtl/fetch_seq.sv - instruction fetch sequencer: PC read, memory handshake, IR hand-off
// Optional feature macro: FETCH_TIMEOUT_EN adds a sticky read-timeout error state.
import fetch_pkg::*;

module fetch_seq #(
  parameter int DATA_W = FETCH_DATA_W,
  parameter int ADDR_W = FETCH_ADDR_W
`ifdef FETCH_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = FETCH_TIMEOUT_CYCLES
`endif
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_out,
  output logic              pc_inc,
  output logic              pc_ld,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic [DATA_W-1:0] ir_out,
  output logic              ir_valid,
  input  logic              ir_taken,
  input  logic              br_taken,
  input  logic              halt,
  output logic              fetch_err
);

  fetch_state_t state_q;
  fetch_state_t state_d;
  logic         mem_rd_d;
  logic         pc_inc_d;
  logic         pc_ld_d;
  logic         ir_valid_d;
  logic         ir_load;

  assign mem_addr = pc_out;

`ifdef FETCH_TIMEOUT_EN
  logic tmo_expired;

  fetch_timeout_ctr #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q != REQ),
    .enable (state_q == REQ && !mem_ack),
    .expired(tmo_expired)
  );

  // ERR is only left through reset, so the flag is sticky by construction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_err <= 1'b0;
    end else begin
      fetch_err <= (state_d == ERR);
    end
  end
`else
  assign fetch_err = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    mem_rd_d   = 1'b0;
    pc_inc_d   = 1'b0;
    pc_ld_d    = 1'b0;
    ir_valid_d = ir_valid;
    ir_load    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!halt) begin
          state_d  = REQ;
          mem_rd_d = 1'b1;
        end
      end
      REQ: begin
        mem_rd_d = 1'b1;
        if (mem_ack) begin
          ir_load    = 1'b1;
          ir_valid_d = 1'b1;
          mem_rd_d   = 1'b0;
          pc_inc_d   = 1'b1;
          state_d    = HOLD;
        end
`ifdef FETCH_TIMEOUT_EN
        else if (tmo_expired) begin
          mem_rd_d = 1'b0;
          state_d  = ERR;
        end
`endif
      end
      HOLD: begin
        if (ir_taken && ir_valid) begin
          ir_valid_d = 1'b0;
          if (br_taken) begin
            pc_ld_d = 1'b1;
            state_d = REDIR;
          end else if (halt) begin
            state_d = IDLE;
          end else begin
            state_d  = REQ;
            mem_rd_d = 1'b1;
          end
        end
      end
      REDIR: begin
        if (halt) begin
          state_d = IDLE;
        end else begin
          state_d  = REQ;
          mem_rd_d = 1'b1;
        end
      end
      ERR: begin
        state_d = ERR;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      mem_rd   <= 1'b0;
      pc_inc   <= 1'b0;
      pc_ld    <= 1'b0;
      ir_valid <= 1'b0;
      ir_out   <= '0;
    end else begin
      state_q  <= state_d;
      mem_rd   <= mem_rd_d;
      pc_inc   <= pc_inc_d;
      pc_ld    <= pc_ld_d;
      ir_valid <= ir_valid_d;
      if (ir_load) begin
        ir_out <= mem_rdata;
      end
    end
  end

  // pc_ld lives only in the single REDIR cycle; pc_inc and pc_ld never overlap.
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert (!(pc_inc && pc_ld));
      assert (!pc_ld || state_q == REDIR);
    end
  end

endmodule

// File: tb/tb_fetch_seq.sv
// tb/tb_fetch_seq.sv - directed bench for fetch_seq with a behavioural PC
// Timeout steps run when FETCH_TIMEOUT_EN is defined.
module tb_fetch_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] pc = 16'h0000;
  logic [15:0] alu;
  logic        pc_inc;
  logic        pc_ld;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [15:0] mem_rdata;
  logic        mem_ack;
  logic [15:0] ir_out;
  logic        ir_valid;
  logic        ir_taken;
  logic        br_taken;
  logic        halt;
  logic        fetch_err;

  int checks = 0;
  int errors = 0;
  int inc_total = 0;
  int ld_total = 0;
  int rd_total = 0;
  int inc0;
  int ld0;
  int rd0;

  fetch_seq dut (
    .clk      (clk),
    .reset    (reset),
    .pc_out   (pc),
    .pc_inc   (pc_inc),
    .pc_ld    (pc_ld),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .mem_rdata(mem_rdata),
    .mem_ack  (mem_ack),
    .ir_out   (ir_out),
    .ir_valid (ir_valid),
    .ir_taken (ir_taken),
    .br_taken (br_taken),
    .halt     (halt),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  // Program counter and pulse/request cycle monitors.
  always @(posedge clk) begin
    if (pc_ld) pc <= alu;
    else if (pc_inc) pc <= pc + 16'd1;
    if (pc_inc) inc_total <= inc_total + 1;
    if (pc_ld) ld_total <= ld_total + 1;
    if (mem_rd) rd_total <= rd_total + 1;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1; halt = 1'b1; mem_ack = 1'b0; mem_rdata = '0;
    ir_taken = 1'b0; br_taken = 1'b0; alu = '0;
    step(); step();
    chk("rst_mem_rd", mem_rd, 0);
    chk("rst_ir_valid", ir_valid, 0);
    chk("rst_ir_out", ir_out, 0);
    chk("rst_pc_inc", pc_inc, 0);
    chk("rst_pc_ld", pc_ld, 0);
    chk("rst_fetch_err", fetch_err, 0);

    // zero-wait fetch
    reset = 1'b0; halt = 1'b0; mem_ack = 1'b1; mem_rdata = 16'h1234;
    step();
    inc0 = inc_total;
    chk("zw_mem_rd", mem_rd, 1);
    chk("zw_addr", mem_addr, 16'h0000);
    chk("zw_ir_valid_early", ir_valid, 0);
    step();
    chk("zw_ir_out", ir_out, 16'h1234);
    chk("zw_ir_valid", ir_valid, 1);
    chk("zw_pc_inc", pc_inc, 1);
    chk("zw_mem_rd_low", mem_rd, 0);
    mem_ack = 1'b0; halt = 1'b1;
    step();
    chk("zw_pc_inc_width", pc_inc, 0);
    chk("zw_pc_next", mem_addr, 16'h0001);
    chk("zw_inc_count", inc_total - inc0, 1);

    // backpressure then halt
    for (int i = 0; i < 5; i++) begin
      step();
      chk("bp_ir_valid", ir_valid, 1);
      chk("bp_ir_out", ir_out, 16'h1234);
      chk("bp_mem_rd", mem_rd, 0);
    end
    ir_taken = 1'b1;
    step();
    ir_taken = 1'b0;
    chk("halt_ir_valid", ir_valid, 0);
    rd0 = rd_total;
    step(); step(); step();
    chk("halt_no_req", rd_total - rd0, 0);
    chk("halt_mem_rd", mem_rd, 0);

    // three wait states
    halt = 1'b0; mem_rdata = 16'hBEEF; inc0 = inc_total; rd0 = rd_total;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("ws_mem_rd", mem_rd, 1);
      chk("ws_addr", mem_addr, 16'h0001);
      step();
    end
    mem_ack = 1'b1;
    chk("ws_addr_last", mem_addr, 16'h0001);
    step();
    mem_ack = 1'b0;
    chk("ws_ir_out", ir_out, 16'hBEEF);
    chk("ws_ir_valid", ir_valid, 1);
    chk("ws_rd_cycles", rd_total - rd0, 4);
    step();
    chk("ws_inc_count", inc_total - inc0, 1);
    chk("ws_pc_next", mem_addr, 16'h0002);

    // branch redirect
    alu = 16'h0040; ir_taken = 1'b1; br_taken = 1'b1; ld0 = ld_total; inc0 = inc_total;
    step();
    ir_taken = 1'b0; br_taken = 1'b0;
    chk("br_pc_ld", pc_ld, 1);
    chk("br_pc_inc", pc_inc, 0);
    chk("br_ir_valid", ir_valid, 0);
    chk("br_mem_rd", mem_rd, 0);
    mem_ack = 1'b1; mem_rdata = 16'h5555;
    step();
    chk("br_target_addr", mem_addr, 16'h0040);
    chk("br_mem_rd_after", mem_rd, 1);
    chk("br_pc_ld_width", pc_ld, 0);
    chk("br_ld_count", ld_total - ld0, 1);
    chk("br_no_inc", inc_total - inc0, 0);
    step();
    chk("br_ir_out", ir_out, 16'h5555);
    mem_ack = 1'b0; halt = 1'b1; ir_taken = 1'b1;
    step();
    ir_taken = 1'b0;
    chk("br_idle_ir_valid", ir_valid, 0);

    // reset during REQ
    halt = 1'b0;
    step(); step();
    chk("mid_mem_rd", mem_rd, 1);
    chk("mid_addr", mem_addr, 16'h0041);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_rst_mem_rd", mem_rd, 0);
    chk("mid_rst_ir_valid", ir_valid, 0);
    chk("mid_rst_ir_out", ir_out, 0);
    step();
    reset = 1'b0; mem_ack = 1'b1; mem_rdata = 16'hA5A5;
    step();
    chk("mid_restart_addr", mem_addr, 16'h0041);
    chk("mid_restart_rd", mem_rd, 1);
    step();
    chk("mid_ir_out", ir_out, 16'hA5A5);
    chk("mid_ir_valid", ir_valid, 1);
    mem_ack = 1'b0; halt = 1'b1; ir_taken = 1'b1;
    step();
    ir_taken = 1'b0;

`ifdef FETCH_TIMEOUT_EN
    reset = 1'b1;
    step();
    reset = 1'b0; halt = 1'b0; mem_ack = 1'b0;
    step();
    repeat (14) step();
    chk("tmo_err_before", fetch_err, 0);
    chk("tmo_rd_before", mem_rd, 1);
    step();
    chk("tmo_err", fetch_err, 1);
    chk("tmo_rd_low", mem_rd, 0);
    mem_ack = 1'b1;
    step(); step();
    chk("tmo_err_sticky", fetch_err, 1);
    chk("tmo_no_ir", ir_valid, 0);
    chk("tmo_rd_stays_low", mem_rd, 0);
    reset = 1'b1; mem_ack = 1'b0;
    step();
    chk("tmo_err_cleared", fetch_err, 0);
    reset = 1'b0; mem_rdata = 16'hC0DE;
    step();
    repeat (14) step();
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    chk("tmo_ack_wins_err", fetch_err, 0);
    chk("tmo_ack_wins_valid", ir_valid, 1);
    chk("tmo_ack_wins_ir", ir_out, 16'hC0DE);
`else
    halt = 1'b0; mem_ack = 1'b0;
    step();
    repeat (20) step();
    chk("notmo_err", fetch_err, 0);
    chk("notmo_rd_waiting", mem_rd, 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_seq.md
Name: fetch_seq

Overview:
- Instruction-fetch sequencer that sits on the consumer side of the 16-bit program counter.
- Reads the PC value, runs a read handshake with instruction memory and latches the returned word into an instruction register.
- Hands the instruction to the execute control through a valid/taken handshake.
- Drives the PC's pc_inc and pc_ld controls; only one of the two is ever asserted in a cycle.

Parameters:
- DATA_W, 16, instruction word width.
- ADDR_W, 16, address width; equals the PC width.
- TIMEOUT_CYCLES, 15, maximum REQ cycles without mem_ack. Used only when FETCH_TIMEOUT_EN is defined.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- pc_out  in  ADDR_W  current PC value.
- pc_inc  out  1  one-cycle pulse: PC += 1.
- pc_ld  out  1  one-cycle pulse: PC loads the ALU result (branch target).
- mem_rd  out  1  memory read request, registered.
- mem_addr  out  ADDR_W  read address, combinational copy of pc_out.
- mem_rdata  in  DATA_W  read data, valid when mem_ack=1.
- mem_ack  in  1  read complete; may arrive 0..n cycles after mem_rd rises.
- ir_out  out  DATA_W  latched instruction.
- ir_valid  out  1  ir_out holds an unconsumed instruction.
- ir_taken  in  1  execute control consumes ir_out.
- br_taken  in  1  redirect request; sampled only on the edge where ir_taken=1 and ir_valid=1.
- halt  in  1  stop fetching at the next instruction boundary.
- fetch_err  out  1  sticky fetch timeout flag; tied to 0 without FETCH_TIMEOUT_EN.

Behaviour:
- States: IDLE, REQ, HOLD, REDIR, plus ERR with the optional feature.
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state goes to IDLE;
  - mem_rd, pc_inc, pc_ld, ir_valid and fetch_err go to 0;
  - ir_out goes to 0.
- IDLE:
  - mem_rd=0.
  - halt=0 at the edge: go to REQ and set mem_rd<=1.
- REQ:
  - mem_rd=1; mem_addr=pc_out, with the PC stable throughout this state.
  - mem_ack=0: remain in REQ.
  - mem_ack=1 at the edge: ir_out<=mem_rdata, ir_valid<=1, mem_rd<=0, pc_inc<=1 for exactly one cycle, then go to HOLD.
  - halt during REQ is ignored; the transaction always completes.
- Zero-wait latency: with ack in the first REQ cycle, ir_valid rises 2 edges after leaving IDLE.
- HOLD:
  - ir_valid=1 and ir_out stable until ir_taken=1 at an edge; at that edge ir_valid<=0.
  - br_taken=1: pc_ld<=1 for one cycle and go to REDIR.
  - Otherwise, halt=1: go to IDLE.
  - Otherwise: go to REQ with mem_rd<=1. pc_out has already been incremented by the earlier pc_inc pulse.
- REDIR:
  - One cycle with mem_rd=0 while the PC loads the target.
  - Next state is IDLE if halt=1, else REQ.
  - When br_taken and halt coincide, the branch load is still performed first.
- ir_taken while ir_valid=0 is ignored. br_taken without ir_taken is ignored.
- pc_inc and pc_ld are each at most one cycle wide and never high together. This invariant is checked by an assertion.
- Back-to-back throughput with zero-wait memory and ir_taken held high: one instruction every 2 cycles.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter clears on entry to REQ and increments on each REQ cycle without mem_ack.
  - When the count reaches TIMEOUT_CYCLES, go to ERR: mem_rd<=0, fetch_err<=1, no pc_inc.
  - ERR is exited only by reset.
  - mem_ack arriving on the same edge as expiry wins; the fetch completes normally.
- Not defined: no counter; REQ waits indefinitely; fetch_err is constant 0.

Decomposition:
- Shared package fetch_pkg:
  - state encoding constants IDLE=0, REQ=1, HOLD=2, REDIR=3, ERR=4, on a 3-bit state type;
  - DATA_W and ADDR_W defaults;
  - TIMEOUT_CYCLES default.
- One sub-module, fetch_timeout_ctr: clear/enable/expired counter, instantiated only under FETCH_TIMEOUT_EN.

Test Plan:
- Zero-wait fetch: reset, then release with PC=0x0000 and mem_rdata=0x1234 with ack in the first REQ cycle -> mem_addr=0x0000, ir_out=0x1234, ir_valid=1, one pc_inc pulse, PC=0x0001.
- Wait states: ack delayed 3 cycles with mem_rdata=0xBEEF -> mem_rd high for 4 cycles, address constant, a single pc_inc, ir_out=0xBEEF.
- Branch: ir_taken=1 and br_taken=1 in HOLD with ALU=0x0040 -> one pc_ld pulse, no pc_inc, one REDIR cycle, next mem_addr=0x0040.
- Backpressure/halt: ir_taken held low for 5 cycles -> ir_valid and ir_out stable, mem_rd=0; then ir_taken=1 with halt=1 -> IDLE with no further requests.
- Reset mid-transaction: assert reset in REQ -> mem_rd and ir_valid go to 0 immediately; after release, fetch restarts at the current pc_out.
- FETCH_TIMEOUT_EN with TIMEOUT_CYCLES=15 and no ack -> fetch_err=1 after 15 REQ cycles, mem_rd=0, sticky until reset. Ack on cycle 15 -> normal completion with fetch_err=0.
